sort_sequencer: RTL and testbench



---
 rtl/sort_sequencer_pkg.sv | 26 ++
 rtl/sort_sequencer_therm_decode.sv | 21 ++
 rtl/sort_sequencer.sv | 130 +++++++++++++
 tb/tb_sort_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_sequencer_pkg.sv
// Shared types and helpers for blocks that drive or consume the latch-based bubble sorter.
package sort_sequencer_pkg;

  typedef enum logic [1:0] {StIdle, StPre, StSort, StOut} seq_state_e;

  // Widest sorted word therm_check accepts; narrower words are zero-extended.
  localparam int unsigned MaxW = 64;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Any 0 below a 1 breaks the thermometer (ones packed toward bit 0).
  function automatic logic therm_check(input logic [MaxW-1:0] word, input int unsigned width);
    logic err;
    err = 1'b0;
    for (int i = 0; i < MaxW - 1; i++) begin
      if (i + 1 < int'(width)) err = err | (word[i+1] & ~word[i]);
    end
    return err;
  endfunction

endpackage

// File: rtl/sort_sequencer_therm_decode.sv
// Combinational decode of a sorted word: popcount plus thermometer-integrity flag.
module therm_decode
  import sort_sequencer_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = clog2(W + 1)
) (
  input  logic [W-1:0]  word_i,
  output logic [CW-1:0] count_o,
  output logic          err_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CW'(word_i[i]);
    end
    err_o = therm_check(MaxW'(word_i), W);
  end

endmodule

// File: rtl/sort_sequencer.sv
// Sequences the bubble sorter through precharge/sort phases and returns the decoded result
// over a valid/ready handshake.
module sort_sequencer
  import sort_sequencer_pkg::*;
#(
  parameter int unsigned SAMPLES     = 2,
  parameter int unsigned OSF         = 8,
  parameter int unsigned PRE_CYCLES  = 1,
  parameter int unsigned SORT_CYCLES = 4,
  localparam int unsigned W          = SAMPLES * OSF,
  localparam int unsigned CW         = clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  sort_din,
  output logic          sort_p,
  input  logic [W-1:0]  sort_dout,
  output logic [CW-1:0] count,
  output logic          therm_err,
  output logic          valid,
  input  logic          ready,
  output logic          busy
);

  localparam int unsigned MaxCyc = (PRE_CYCLES > SORT_CYCLES) ? PRE_CYCLES : SORT_CYCLES;
  localparam int unsigned CntW   = clog2(MaxCyc + 1);

  seq_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sort_din_q, sort_din_d;
  logic [CW-1:0] count_q, count_d;
  logic          therm_err_q, therm_err_d;
  logic          valid_q, valid_d;
  logic          sort_p_q, sort_p_d;
  logic          busy_q, busy_d;

  logic [CW-1:0] dec_count;
  logic          dec_err;

  therm_decode #(
    .W  (W),
    .CW (CW)
  ) u_therm_decode (
    .word_i  (sort_dout),
    .count_o (dec_count),
    .err_o   (dec_err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sort_din_d  = sort_din_q;
    count_d     = count_q;
    therm_err_d = therm_err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sort_din_d = din;
          cnt_d      = CntW'(PRE_CYCLES - 1);
          state_d    = StPre;
        end
      end
      StPre: begin
        if (cnt_q == '0) begin
          cnt_d   = CntW'(SORT_CYCLES - 1);
          state_d = StSort;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StSort: begin
        if (cnt_q == '0) begin
          count_d     = dec_count;
          therm_err_d = dec_err;
          state_d     = StOut;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StOut: begin
        if (ready) begin
          if (start) begin
            sort_din_d = din;
            cnt_d      = CntW'(PRE_CYCLES - 1);
            state_d    = StPre;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Outputs are registered from the next state so they never glitch.
    valid_d  = (state_d == StOut);
    sort_p_d = (state_d != StSort);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sort_din_q  <= '0;
      count_q     <= '0;
      therm_err_q <= 1'b0;
      valid_q     <= 1'b0;
      sort_p_q    <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sort_din_q  <= sort_din_d;
      count_q     <= count_d;
      therm_err_q <= therm_err_d;
      valid_q     <= valid_d;
      sort_p_q    <= sort_p_d;
      busy_q      <= busy_d;
    end
  end

  assign sort_din  = sort_din_q;
  assign sort_p    = sort_p_q;
  assign count     = count_q;
  assign therm_err = therm_err_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Self-checking bench for sort_sequencer with a behavioural sorter and result model.
module tb_sort_sequencer;

  localparam int W    = 16;
  localparam int CW   = $clog2(W + 1);
  localparam int PRE  = 1;
  localparam int SORT = 4;
  // Edge count from the accepting edge (counted as 1) to the edge raising valid.
  localparam int LAT  = PRE + SORT + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, ready, force_en;
  logic [W-1:0]  din, sort_din, sort_dout, force_val;
  logic [CW-1:0] count;
  logic          therm_err, valid, busy, sort_p;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] therm_of(input int n);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Ideal sorter: ones of the held word packed toward bit 0, unless a fault word is forced.
  assign sort_dout = force_en ? force_val : therm_of($countones(sort_din));

  sort_sequencer #(
    .SAMPLES     (2),
    .OSF         (8),
    .PRE_CYCLES  (PRE),
    .SORT_CYCLES (SORT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .din       (din),
    .sort_din  (sort_din),
    .sort_p    (sort_p),
    .sort_dout (sort_dout),
    .count     (count),
    .therm_err (therm_err),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // A valid thermometer word equals the packed form of its own popcount.
  function automatic int model_err(input logic [W-1:0] w);
    return (w != therm_of($countones(w))) ? 1 : 0;
  endfunction

  task automatic convert(input logic [W-1:0] d, output int lat, output int low_cnt,
                         output int din_ok);
    @(negedge clk);
    din   = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    lat     = 1;
    low_cnt = 0;
    din_ok  = 1;
    while (!valid && lat < 40) begin
      if (!sort_p) low_cnt++;
      if (sort_din !== d) din_ok = 0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check({tag, "_valid_clr"}, int'(valid), 0);
    check({tag, "_busy_clr"}, int'(busy), 0);
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic         fen;
    logic [W-1:0] fval;
    int           exp_count;
    int           exp_err;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int lat, low_cnt, din_ok, ok, nv, e, busy_ok, valid_ok;
    int vidx[3];
    logic [W-1:0] d, w, exp_sd;
    logic [W-1:0] bb[3];
    logic [CW-1:0] held_count;

    vecs[0] = '{16'hA5A5, 1'b0, 16'h0000, 8, 0};
    vecs[1] = '{16'hA5A5, 1'b1, 16'h00FD, 7, 1};
    vecs[2] = '{16'h1234, 1'b1, 16'h0000, 0, 0};
    vecs[3] = '{16'h1234, 1'b1, 16'hFFFF, 16, 0};
    vecs[4] = '{16'h0001, 1'b1, 16'h8000, 1, 1};
    vecs[5] = '{16'h0001, 1'b0, 16'h0000, 1, 0};

    rst_n = 1'b0; start = 1'b0; ready = 1'b0; din = '0; force_en = 1'b0; force_val = '0;
    #12;
    check("rst_sort_p", int'(sort_p), 1);
    check("rst_sort_din", int'(sort_din), 0);
    check("rst_count", int'(count), 0);
    check("rst_therm_err", int'(therm_err), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      force_en  = vecs[k].fen;
      force_val = vecs[k].fval;
      convert(vecs[k].din, lat, low_cnt, din_ok);
      check($sformatf("v%0d_latency", k), lat, LAT);
      check($sformatf("v%0d_sort_low", k), low_cnt, SORT);
      check($sformatf("v%0d_din_stable", k), din_ok, 1);
      check($sformatf("v%0d_count", k), int'(count), vecs[k].exp_count);
      check($sformatf("v%0d_err", k), int'(therm_err), vecs[k].exp_err);
      handshake($sformatf("v%0d", k));
    end

    // Result held under backpressure; stray starts ignored.
    force_en = 1'b0;
    convert(16'h0F0F, lat, low_cnt, din_ok);
    held_count = count;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = i[0];
      din   = 16'hFFFF;
      @(posedge clk);
      #1;
      if (!valid || count != held_count || !sort_p || sort_din != 16'h0F0F || therm_err)
        ok = 0;
    end
    start = 1'b0;
    check("hold_count_val", int'(held_count), 8);
    check("hold_stable", ok, 1);
    handshake("hold");
    check("hold_no_queue_sort_din", int'(sort_din), 16'h0F0F);

    // Back-to-back conversions with start and ready held high.
    bb[0] = 16'h0003; bb[1] = 16'h7F00; bb[2] = 16'hFFF0;
    @(negedge clk);
    din = bb[0]; start = 1'b1; ready = 1'b1;
    nv = 0; exp_sd = bb[0]; din_ok = 1; busy_ok = 1; valid_ok = 1;
    for (e = 0; e <= 18; e++) begin
      @(posedge clk);
      #1;
      if (e < 18) begin
        if (sort_din != exp_sd) din_ok = 0;
        if (!busy) busy_ok = 0;
        if (valid) begin
          if (nv < 3) begin
            vidx[nv] = e;
            if (int'(count) != $countones(bb[nv])) valid_ok = 0;
          end
          nv++;
          if (nv < 3) begin
            din = bb[nv];
            exp_sd = bb[nv];
          end else begin
            start = 1'b0;
          end
        end
      end
    end
    ready = 1'b0;
    check("b2b_results", nv, 3);
    check("b2b_first", (nv >= 1) ? vidx[0] : -1, LAT - 1);
    check("b2b_space1", (nv >= 2) ? vidx[1] - vidx[0] : -1, LAT);
    check("b2b_space2", (nv >= 3) ? vidx[2] - vidx[1] : -1, LAT);
    check("b2b_counts", valid_ok, 1);
    check("b2b_sort_din", din_ok, 1);
    check("b2b_busy", busy_ok, 1);
    check("b2b_idle_after", int'(busy), 0);

    // Asynchronous reset during SORT discards the result.
    convert_abort: begin
      @(negedge clk);
      din = 16'h00FF; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      check("abort_in_sort", int'(sort_p), 0);
      rst_n = 1'b0;
      #1;
      check("abort_sort_p", int'(sort_p), 1);
      check("abort_busy", int'(busy), 0);
      check("abort_valid", int'(valid), 0);
      check("abort_sort_din", int'(sort_din), 0);
      check("abort_count", int'(count), 0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    convert(16'h0707, lat, low_cnt, din_ok);
    check("post_rst_latency", lat, LAT);
    check("post_rst_count", int'(count), 6);
    handshake("post_rst");

    // Randomized words and fault patterns against the model.
    for (int i = 0; i < 30; i++) begin
      d = W'($urandom);
      force_en  = 1'($urandom_range(0, 1));
      force_val = W'($urandom);
      w = force_en ? force_val : therm_of($countones(d));
      convert(d, lat, low_cnt, din_ok);
      check($sformatf("rnd%0d_latency", i), lat, LAT);
      check($sformatf("rnd%0d_count", i), int'(count), $countones(w));
      check($sformatf("rnd%0d_err", i), int'(therm_err), model_err(w));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      handshake($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
